// File: rtl/ibex_probe_ctrl_pkg.sv
// Shared types for the Ibex probe controller: FSM state encoding and verdict codes.
package ibex_probe_pkg;

    typedef enum logic [2:0] {
        IDLE,
        BOOT,
        RUN,
        DEBUG,
        DONE,
        FAIL
    } probe_state_e;

    localparam logic [1:0] FAIL_NONE    = 2'd0;
    localparam logic [1:0] FAIL_MAJOR   = 2'd1;
    localparam logic [1:0] FAIL_TIMEOUT = 2'd2;

    function automatic logic is_running(probe_state_e s);
        return (s == RUN) || (s == DEBUG);
    endfunction

    function automatic logic is_active(probe_state_e s);
        return (s == BOOT) || (s == RUN) || (s == DEBUG);
    endfunction

endpackage

// File: rtl/ibex_probe_ctrl_if.sv
// Probe bundle between the bench top and the controller: core status in, core controls and verdict out.
interface ibex_probe_ctrl_if #(
    parameter int CNT_W = 32
);
    logic             start_i;
    logic             dbg_trig_i;
    logic             ecall_i;
    logic             core_sleep_i;
    logic             alert_minor_i;
    logic             alert_major_i;
    logic             fetch_enable_o;
    logic             debug_req_o;
    logic             busy_o;
    logic             done_o;
    logic             pass_o;
    logic             fail_o;
    logic [1:0]       fail_code_o;
    logic [7:0]       minor_cnt_o;
    logic [CNT_W-1:0] sleep_cnt_o;
    logic [CNT_W-1:0] cycle_cnt_o;

    modport master (
        output start_i, dbg_trig_i, ecall_i, core_sleep_i, alert_minor_i, alert_major_i,
        input  fetch_enable_o, debug_req_o, busy_o, done_o, pass_o, fail_o,
        input  fail_code_o, minor_cnt_o, sleep_cnt_o, cycle_cnt_o
    );

    modport slave (
        input  start_i, dbg_trig_i, ecall_i, core_sleep_i, alert_minor_i, alert_major_i,
        output fetch_enable_o, debug_req_o, busy_o, done_o, pass_o, fail_o,
        output fail_code_o, minor_cnt_o, sleep_cnt_o, cycle_cnt_o
    );
endinterface

// File: rtl/ibex_probe_ctrl_ctr.sv
// Loadable down-counter that stops at zero; used for the boot delay and the debug pulse width.
module ibex_probe_ctr #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         zero
);
    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);
endmodule

// File: rtl/ibex_probe_ctrl.sv
// Ibex test-harness sequencer: boot delay, debug pulses, end-of-test verdict and run statistics.
//
// state | meaning
// IDLE  | after reset, waiting for start
// BOOT  | fetch held off for BOOT_DELAY cycles
// RUN   | core fetching, watching for ecall / alerts / timeout
// DEBUG | debug_req asserted for DBG_PULSE cycles
// DONE  | ecall seen, pass verdict held
// FAIL  | major alert or timeout, fail verdict held
module ibex_probe_ctrl
    import ibex_probe_pkg::*;
#(
    parameter int BOOT_DELAY = 16,
    parameter int DBG_PULSE  = 4,
    parameter int TIMEOUT    = 100000,
    parameter int CNT_W      = 32
) (
    input  logic         clk,
    input  logic         rst,
    ibex_probe_ctrl_if.slave pif
);
    localparam int DLY_MAX = (BOOT_DELAY > DBG_PULSE) ? BOOT_DELAY : DBG_PULSE;
    localparam int DLY_W   = $clog2(DLY_MAX + 1);

    probe_state_e     state, state_n;
    logic             boot_load, dbg_load, boot_zero, dbg_zero, timeout_hit;
    logic             fetch_enable, debug_req, busy, done, pass, fail;
    logic [1:0]       fail_code;
    logic [7:0]       minor_cnt;
    logic [CNT_W-1:0] sleep_cnt, cycle_cnt;

    ibex_probe_ctr #(.W(DLY_W)) u_boot_ctr (
        .clk      (clk),
        .rst      (rst),
        .load     (boot_load),
        .load_val (DLY_W'(BOOT_DELAY - 1)),
        .en       (state == BOOT),
        .zero     (boot_zero)
    );

    ibex_probe_ctr #(.W(DLY_W)) u_dbg_ctr (
        .clk      (clk),
        .rst      (rst),
        .load     (dbg_load),
        .load_val (DLY_W'(DBG_PULSE - 1)),
        .en       (state == DEBUG),
        .zero     (dbg_zero)
    );

    assign timeout_hit = (cycle_cnt == CNT_W'(TIMEOUT));

    // Termination outranks debug trigger and pulse end.
    always_comb begin
        state_n = state;
        case (state)
            IDLE:       if (pif.start_i) state_n = BOOT;
            BOOT: begin
                if (pif.alert_major_i)  state_n = FAIL;
                else if (boot_zero)     state_n = RUN;
            end
            RUN, DEBUG: begin
                if (pif.alert_major_i)                   state_n = FAIL;
                else if (pif.ecall_i)                    state_n = DONE;
                else if (timeout_hit)                    state_n = FAIL;
                else if (state == RUN && pif.dbg_trig_i) state_n = DEBUG;
                else if (state == DEBUG && dbg_zero)     state_n = RUN;
            end
            DONE, FAIL: if (pif.start_i) state_n = BOOT;
            default:    state_n = IDLE;
        endcase
    end

    assign boot_load = (state_n == BOOT)  && (state != BOOT);
    assign dbg_load  = (state_n == DEBUG) && (state != DEBUG);

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            fetch_enable <= 1'b0;
            debug_req    <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            pass         <= 1'b0;
            fail         <= 1'b0;
            fail_code    <= FAIL_NONE;
            minor_cnt    <= '0;
            sleep_cnt    <= '0;
            cycle_cnt    <= '0;
        end else begin
            state        <= state_n;
            fetch_enable <= is_running(state_n);
            debug_req    <= (state_n == DEBUG);
            busy         <= is_active(state_n);
            done         <= (state_n == DONE) || (state_n == FAIL);
            pass         <= (state_n == DONE);
            fail         <= (state_n == FAIL);
            if (boot_load) begin
                fail_code <= FAIL_NONE;
                minor_cnt <= '0;
                sleep_cnt <= '0;
                cycle_cnt <= '0;
            end else begin
                if (state_n == FAIL && state != FAIL)
                    fail_code <= pif.alert_major_i ? FAIL_MAJOR : FAIL_TIMEOUT;
                // Cycle count parks at TIMEOUT so the verdict reports the limit itself.
                if (is_running(state) && !timeout_hit) begin
                    cycle_cnt <= cycle_cnt + 1'b1;
                    if (pif.core_sleep_i) sleep_cnt <= sleep_cnt + 1'b1;
                end
                if (is_active(state) && pif.alert_minor_i && minor_cnt != 8'hFF)
                    minor_cnt <= minor_cnt + 1'b1;
            end
        end
    end

    assign pif.fetch_enable_o = fetch_enable;
    assign pif.debug_req_o    = debug_req;
    assign pif.busy_o         = busy;
    assign pif.done_o         = done;
    assign pif.pass_o         = pass;
    assign pif.fail_o         = fail;
    assign pif.fail_code_o    = fail_code;
    assign pif.minor_cnt_o    = minor_cnt;
    assign pif.sleep_cnt_o    = sleep_cnt;
    assign pif.cycle_cnt_o    = cycle_cnt;
endmodule

// File: tb/tb_ibex_probe_ctrl.sv
// Directed bench for ibex_probe_ctrl: expectations queued at stimulus time, popped when the DUT responds.
module tb_ibex_probe_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ibex_probe_ctrl_if #(.CNT_W(32)) pif ();
    ibex_probe_ctrl_if #(.CNT_W(32)) pif2 ();

    ibex_probe_ctrl #(.BOOT_DELAY(16), .DBG_PULSE(4), .TIMEOUT(100), .CNT_W(32)) u_dut (
        .clk (clk),
        .rst (rst),
        .pif (pif)
    );

    // Long timeout instance so a minor alert can be held long enough to saturate.
    ibex_probe_ctrl #(.BOOT_DELAY(16), .DBG_PULSE(4), .TIMEOUT(1000), .CNT_W(32)) u_dut2 (
        .clk (clk),
        .rst (rst),
        .pif (pif2)
    );

    typedef struct {
        string       tag;
        logic [63:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_mis = 0;
    int   cyc   = 0;

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic push(input string tag, input logic [63:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic check(input logic [63:0] obs);
        exp_t e;
        n_cmp++;
        if (sb.size() == 0) begin
            n_mis++;
            $error("FAIL scoreboard_empty: observed %0d expected <none>", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                n_mis++;
                $error("FAIL %s: observed %0d expected %0d", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic wait_fetch(input string tag);
        push(tag, 64'(cyc + 16));
        for (int i = 0; i < 40 && !pif.fetch_enable_o; i++) step();
        check(64'(cyc));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "bench timeout");
    end

    initial begin
        int r;
        int n;
        int extra;

        {pif.start_i, pif.dbg_trig_i, pif.ecall_i, pif.core_sleep_i, pif.alert_minor_i, pif.alert_major_i} = '0;
        {pif2.start_i, pif2.dbg_trig_i, pif2.ecall_i, pif2.core_sleep_i, pif2.alert_minor_i, pif2.alert_major_i} = '0;

        // Reset state
        rst = 1'b1;
        repeat (3) step();
        push("rst_fetch", 0);  check(64'(pif.fetch_enable_o));
        push("rst_busy", 0);   check(64'(pif.busy_o));
        push("rst_done", 0);   check(64'(pif.done_o));
        push("rst_code", 0);   check(64'(pif.fail_code_o));
        push("rst_cycle", 0);  check(64'(pif.cycle_cnt_o));
        rst = 1'b0;
        step();

        // IDLE ignores everything but start
        pif.dbg_trig_i = 1'b1; pif.ecall_i = 1'b1; pif.alert_major_i = 1'b1;
        push("idle_busy", 0);
        push("idle_done", 0);
        step();
        pif.dbg_trig_i = 1'b0; pif.ecall_i = 1'b0; pif.alert_major_i = 1'b0;
        check(64'(pif.busy_o));
        check(64'(pif.done_o));

        // Nominal pass
        pif.start_i = 1'b1;
        push("boot_busy", 1);
        push("boot_fetch", 0);
        step();
        pif.start_i = 1'b0;
        check(64'(pif.busy_o));
        check(64'(pif.fetch_enable_o));
        wait_fetch("fetch_rise_nom");
        repeat (50) step();
        pif.ecall_i = 1'b1;
        push("nom_done", 1); push("nom_pass", 1); push("nom_fail", 0);
        push("nom_cycle", 51); push("nom_fetch", 0); push("nom_busy", 0);
        step();
        pif.ecall_i = 1'b0;
        check(64'(pif.done_o)); check(64'(pif.pass_o)); check(64'(pif.fail_o));
        check(64'(pif.cycle_cnt_o)); check(64'(pif.fetch_enable_o)); check(64'(pif.busy_o));
        push("nom_cycle_frozen", 51);
        repeat (5) step();
        check(64'(pif.cycle_cnt_o));

        // Restart clears verdict, then debug pulse
        pif.start_i = 1'b1;
        push("rs_pass", 0); push("rs_done", 0); push("rs_cycle", 0);
        step();
        pif.start_i = 1'b0;
        check(64'(pif.pass_o)); check(64'(pif.done_o)); check(64'(pif.cycle_cnt_o));
        wait_fetch("fetch_rise_dbg");
        repeat (3) step();
        pif.dbg_trig_i = 1'b1;
        push("dbg_len", 4);
        step();
        pif.dbg_trig_i = 1'b0;
        n = 0;
        for (int i = 0; i < 20 && pif.debug_req_o; i++) begin
            n++;
            pif.dbg_trig_i = (n == 2);
            step();
        end
        pif.dbg_trig_i = 1'b0;
        check(64'(n));
        push("dbg_back_fetch", 1); push("dbg_back_busy", 1); push("dbg_no_retrig", 0);
        check(64'(pif.fetch_enable_o));
        check(64'(pif.busy_o));
        extra = 0;
        repeat (5) begin
            step();
            if (pif.debug_req_o) extra++;
        end
        check(64'(extra));

        // Major alert and ecall together: fail wins
        pif.ecall_i = 1'b1; pif.alert_major_i = 1'b1;
        push("both_fail", 1); push("both_code", 1); push("both_pass", 0); push("both_done", 1); push("both_fetch", 0);
        step();
        pif.ecall_i = 1'b0; pif.alert_major_i = 1'b0;
        check(64'(pif.fail_o)); check(64'(pif.fail_code_o)); check(64'(pif.pass_o));
        check(64'(pif.done_o)); check(64'(pif.fetch_enable_o));

        // Major alert during BOOT
        pif.start_i = 1'b1;
        push("boot_code_clr", 0);
        step();
        pif.start_i = 1'b0;
        check(64'(pif.fail_code_o));
        repeat (3) step();
        pif.alert_major_i = 1'b1;
        push("bootmaj_fail", 1); push("bootmaj_code", 1); push("bootmaj_fetch", 0); push("bootmaj_busy", 0);
        step();
        pif.alert_major_i = 1'b0;
        check(64'(pif.fail_o)); check(64'(pif.fail_code_o));
        check(64'(pif.fetch_enable_o)); check(64'(pif.busy_o));

        // Watchdog timeout with 30 sleep cycles
        pif.start_i = 1'b1;
        step();
        pif.start_i = 1'b0;
        wait_fetch("fetch_rise_to");
        r = cyc;
        repeat (5) step();
        pif.core_sleep_i = 1'b1;
        repeat (30) step();
        pif.core_sleep_i = 1'b0;
        push("to_edge", 64'(r + 101));
        for (int i = 0; i < 200 && !pif.done_o; i++) step();
        check(64'(cyc));
        push("to_code", 2); push("to_fail", 1); push("to_pass", 0); push("to_cycle", 100); push("to_sleep", 30);
        check(64'(pif.fail_code_o)); check(64'(pif.fail_o)); check(64'(pif.pass_o));
        check(64'(pif.cycle_cnt_o)); check(64'(pif.sleep_cnt_o));

        // Minor alert saturation, start ignored while busy, then restart clears
        pif2.start_i = 1'b1;
        pif2.alert_minor_i = 1'b1;
        push("minor_sat", 255);
        step();
        pif2.start_i = 1'b0;
        repeat (299) step();
        pif2.alert_minor_i = 1'b0;
        check(64'(pif2.minor_cnt_o));
        pif2.start_i = 1'b1;
        push("busy_start_busy", 1); push("busy_start_fetch", 1); push("busy_start_minor", 255);
        step();
        pif2.start_i = 1'b0;
        check(64'(pif2.busy_o)); check(64'(pif2.fetch_enable_o)); check(64'(pif2.minor_cnt_o));
        pif2.alert_major_i = 1'b1;
        push("d2_fail", 1);
        step();
        pif2.alert_major_i = 1'b0;
        check(64'(pif2.fail_o));
        pif2.start_i = 1'b1;
        push("d2_rs_minor", 0); push("d2_rs_cycle", 0); push("d2_rs_fail", 0);
        push("d2_rs_pass", 0); push("d2_rs_code", 0); push("d2_rs_busy", 1);
        step();
        pif2.start_i = 1'b0;
        check(64'(pif2.minor_cnt_o)); check(64'(pif2.cycle_cnt_o)); check(64'(pif2.fail_o));
        check(64'(pif2.pass_o)); check(64'(pif2.fail_code_o)); check(64'(pif2.busy_o));

        // Reset while in DEBUG
        pif.start_i = 1'b1;
        step();
        pif.start_i = 1'b0;
        wait_fetch("fetch_rise_rst");
        repeat (10) step();
        pif.dbg_trig_i = 1'b1;
        push("pre_rst_dbg", 1);
        step();
        pif.dbg_trig_i = 1'b0;
        check(64'(pif.debug_req_o));
        rst = 1'b1;
        push("rst_dbg", 0); push("rst_dbg_fetch", 0); push("rst_dbg_busy", 0); push("rst_dbg_cycle", 0);
        step();
        rst = 1'b0;
        check(64'(pif.debug_req_o)); check(64'(pif.fetch_enable_o));
        check(64'(pif.busy_o)); check(64'(pif.cycle_cnt_o));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule

// File: doc/ibex_probe_ctrl.md
# ibex_probe_ctrl

Test-harness controller that sequences the special Ibex core control signals: fetch enable, debug request, ecall, sleep and alerts. It sits between the testbench top and the probe signals of the DUT. It releases fetch after a programmable boot delay and issues timed debug-request pulses on command. It ends the test on ecall (pass), major alert (fail) or watchdog timeout (fail), and holds the verdict plus minor-alert and cycle statistics until the next start.

## Interface
Parameters:
- BOOT_DELAY, 16: cycles in BOOT with fetch_enable low before release; must be ≥ 1.
- DBG_PULSE, 4: cycles debug_req_o is held high per trigger; must be ≥ 1.
- TIMEOUT, 100000: run-cycle watchdog limit; must be < 2^CNT_W.
- CNT_W, 32: width of cycle counter.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  core/bench clock; all logic on rising edge.
- rst  in  1  synchronous active-high reset.
- start_i  in  1  pulse; begins a test from IDLE, DONE or FAIL.
- dbg_trig_i  in  1  pulse; request a debug_req pulse.
- ecall_i  in  1  core executed ecall (end-of-test marker).
- core_sleep_i  in  1  core in WFI sleep.
- alert_minor_i  in  1  core minor alert.
- alert_major_i  in  1  core major alert.
- fetch_enable_o  out  1  to core fetch enable.
- debug_req_o  out  1  to core debug request.
- busy_o  out  1  high in BOOT, RUN, DEBUG.
- done_o  out  1  level; test finished (pass or fail).
- pass_o  out  1  level; ecall seen.
- fail_o  out  1  level; major alert or timeout.
- fail_code_o  out  2  0 none, 1 major alert, 2 timeout.
- minor_cnt_o  out  8  saturating count of minor-alert cycles.
- sleep_cnt_o  out  CNT_W  cycles with core_sleep_i high in RUN/DEBUG.
- cycle_cnt_o  out  CNT_W  cycles spent in RUN/DEBUG.

## Operation
- States: IDLE, BOOT, RUN, DEBUG, DONE, FAIL. Reset → IDLE. All outputs and counters reset to 0.
- IDLE: start_i → BOOT. Other inputs are ignored.
- BOOT: a down-counter is loaded with BOOT_DELAY−1 on entry; fetch_enable_o = 0; → RUN when the counter hits 0.
- RUN: fetch_enable_o = 1. dbg_trig_i → DEBUG with the pulse counter loaded DBG_PULSE−1.
- DEBUG: fetch_enable_o = 1, debug_req_o = 1; → RUN when the pulse counter hits 0. dbg_trig_i in DEBUG is dropped, not queued.
- Termination checks in RUN/DEBUG, priority order:
  - alert_major_i → FAIL, code 1.
  - ecall_i → DONE, pass.
  - cycle_cnt_o == TIMEOUT → FAIL, code 2.
  - Termination beats a debug trigger or pulse end in the same cycle.
- alert_major_i in BOOT → FAIL, code 1 (fetch never released).
- DONE/FAIL: fetch_enable_o = 0, debug_req_o = 0, verdict outputs held. start_i → BOOT, clearing the verdict and all counters in the same edge.
- start_i while busy is ignored.
- Counters:
  - cycle_cnt_o increments every RUN/DEBUG cycle.
  - sleep_cnt_o increments when core_sleep_i is also high.
  - minor_cnt_o increments on each alert_minor_i-high cycle in BOOT/RUN/DEBUG and saturates at 255.
  - All counters freeze in DONE/FAIL.

## Timing
- All outputs are registered and Moore-decoded from state; there is no combinational input→output path.
- start_i sampled at edge N → BOOT at N+1 → fetch_enable_o high from edge N+1+BOOT_DELAY.
- dbg_trig_i sampled at edge M in RUN → debug_req_o high for edges M+1 … M+DBG_PULSE, low at M+DBG_PULSE+1.
- ecall_i or alert_major_i sampled at edge K → done_o/pass_o/fail_o high and fetch_enable_o low at K+1.
- Timeout: the edge where cycle_cnt_o == TIMEOUT is registered in RUN moves to FAIL at the next edge.
- rst mid-test → IDLE at the next edge; outputs are low that same cycle.

## Structure
- Package ibex_probe_pkg holds:
  - state enum probe_state_e (IDLE, BOOT, RUN, DEBUG, DONE, FAIL).
  - fail-code localparams FAIL_NONE/FAIL_MAJOR/FAIL_TIMEOUT.
- One sub-module, ibex_probe_ctr: a loadable down-counter with zero flag, instanced for the boot delay and the debug pulse.
- FSM, statistics counters and output decode live in the top module.

## Test plan
- Nominal pass, BOOT_DELAY=16: start at cycle 0 → fetch_enable_o rises at cycle 17; ecall at run cycle 50 → pass_o=1, done_o=1, cycle_cnt_o=51, fetch_enable_o=0.
- Debug pulse, DBG_PULSE=4: trigger in RUN → debug_req_o high for exactly 4 cycles; a second trigger during the pulse produces no extension. After the pulse, state returns to RUN.
- Major alert and ecall in the same cycle → fail_o=1, fail_code_o=1, pass_o=0.
- Timeout: TIMEOUT=100, no ecall → FAIL with fail_code_o=2 and cycle_cnt_o=100. Sleep for 30 of those cycles → sleep_cnt_o=30.
- Minor alert held 300 cycles → minor_cnt_o=255. Then restart via start_i → all counters 0, fail_o/pass_o cleared.
- rst asserted in DEBUG → next cycle IDLE, debug_req_o=0, fetch_enable_o=0, counters 0.
